// File: rtl/cache_refill_engine_pkg.sv
// Shared constants and types for the data-cache refill engine.
//   LINE_TYPE / WORD_TYPE : request type codes on the rd_*/wr_* channels
//   BEATS                 : 32-bit beats per 128-bit line
//   OFFSET_W              : byte-offset bits below the index in a line address
//   refill_state_e        : main FSM state encoding
package cache_refill_engine_pkg;

    localparam logic [2:0] LINE_TYPE = 3'b100;
    localparam logic [2:0] WORD_TYPE = 3'b010;
    localparam int         BEATS     = 4;
    localparam int         OFFSET_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_DONE    = 2'd3
    } refill_state_e;

endpackage

// File: rtl/cache_refill_engine_wbuf.sv
// Single-entry victim write buffer. Captures a dirty victim line on load and
// presents it on the posted write channel until the responder accepts it.
// Ports:
//   clk, resetn             clock, async active-low reset
//   load                    capture victim tag/index/data this cycle
//   load_tag/index/data     victim line address fields and contents
//   wr_rdy                  responder accepts wr_req
//   wr_req, wr_addr, wr_data  write request held stable until accepted
//   empty                   no writeback pending
module cache_wbuf
    import cache_refill_engine_pkg::*;
#(
    parameter int TAG_W   = 20,
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic [TAG_W-1:0]   load_tag,
    input  logic [INDEX_W-1:0] load_index,
    input  logic [127:0]       load_data,
    input  logic               wr_rdy,
    output logic               wr_req,
    output logic [31:0]        wr_addr,
    output logic [127:0]       wr_data,
    output logic               empty
);

    logic         valid_q;
    logic [31:0]  addr_q;
    logic [127:0] data_q;

    // Load is only ever issued while empty (the miss port is blocked
    // otherwise), so load simply takes priority over the drain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            addr_q  <= {load_tag, load_index, {OFFSET_W{1'b0}}};
            data_q  <= load_data;
        end else if (valid_q && wr_rdy) begin
            valid_q <= 1'b0;
        end
    end

    assign wr_req  = valid_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign empty   = !valid_q;

endmodule

// File: rtl/cache_refill_engine.sv
// Data-cache miss engine. Accepts one miss descriptor, posts a dirty victim
// writeback through cache_wbuf, fetches the missing line as four 32-bit
// beats and returns it to the cache as a one-cycle refill pulse.
// Ports:
//   clk, resetn                          clock, async active-low reset
//   miss_valid/ready, miss_tag/index     miss descriptor handshake
//   victim_dirty/tag/data                victim line for writeback
//   refill_valid/tag/index/data          completed line back to the cache
//   rd_req/type/addr, rd_rdy             line read request channel
//   ret_valid/last/data                  read return beats
//   wr_req/type/addr/wstrb/data, wr_rdy  posted victim write channel
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a miss; accepts only when write buffer empty
// ST_RD_REQ  | rd_req held with stable rd_addr until rd_rdy
// ST_RD_DATA | collecting return beats into the line buffer
// ST_DONE    | refill_valid pulse, line/tag/index stable
module cache_refill_engine
    import cache_refill_engine_pkg::*;
#(
    parameter int TAG_W   = 20,
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               miss_valid,
    output logic               miss_ready,
    input  logic [TAG_W-1:0]   miss_tag,
    input  logic [INDEX_W-1:0] miss_index,
    input  logic               victim_dirty,
    input  logic [TAG_W-1:0]   victim_tag,
    input  logic [127:0]       victim_data,
    output logic               refill_valid,
    output logic [TAG_W-1:0]   refill_tag,
    output logic [INDEX_W-1:0] refill_index,
    output logic [127:0]       refill_data,
    output logic               rd_req,
    output logic [2:0]         rd_type,
    output logic [31:0]        rd_addr,
    input  logic               rd_rdy,
    input  logic               ret_valid,
    input  logic               ret_last,
    input  logic [31:0]        ret_data,
    output logic               wr_req,
    output logic [2:0]         wr_type,
    output logic [31:0]        wr_addr,
    output logic [3:0]         wr_wstrb,
    output logic [127:0]       wr_data,
    input  logic               wr_rdy
);

    refill_state_e            state_q, state_d;
    logic [TAG_W-1:0]         tag_q;
    logic [INDEX_W-1:0]       index_q;
    logic [1:0]               cnt_q;
    logic [BEATS-1:0][31:0]   line_q;
    logic                     accept;
    logic                     beat;
    logic                     wbuf_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        miss_ready   = 1'b0;
        rd_req       = 1'b0;
        refill_valid = 1'b0;
        accept       = 1'b0;
        beat         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Holding off new misses while a writeback is pending keeps
                // a read from overtaking the write of the same line.
                miss_ready = wbuf_empty;
                if (miss_valid && wbuf_empty) begin
                    accept  = 1'b1;
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                rd_req = 1'b1;
                if (rd_rdy) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (ret_valid) begin
                    beat = 1'b1;
                    if (ret_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                refill_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line words are not cleared per miss: a short burst leaves stale words
    // in the unfilled slots.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_q   <= '0;
            index_q <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            if (accept) begin
                tag_q   <= miss_tag;
                index_q <= miss_index;
                cnt_q   <= '0;
            end
            if (beat) begin
                line_q[cnt_q] <= ret_data;
                cnt_q         <= cnt_q + 2'd1;
            end
        end
    end

    assign rd_type      = LINE_TYPE;
    assign rd_addr      = {tag_q, index_q, {OFFSET_W{1'b0}}};
    assign refill_tag   = tag_q;
    assign refill_index = index_q;
    assign refill_data  = line_q;
    assign wr_type      = LINE_TYPE;
    assign wr_wstrb     = 4'b1111;

    cache_wbuf #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W)
    ) u_wbuf (
        .clk        (clk),
        .resetn     (resetn),
        .load       (accept && victim_dirty),
        .load_tag   (victim_tag),
        .load_index (miss_index),
        .load_data  (victim_data),
        .wr_rdy     (wr_rdy),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .empty      (wbuf_empty)
    );

endmodule

// File: tb/tb_cache_refill_engine.sv
module tb_cache_refill_engine;

    logic         clk = 1'b0;
    logic         resetn;
    logic         miss_valid;
    logic         miss_ready;
    logic [19:0]  miss_tag;
    logic [7:0]   miss_index;
    logic         victim_dirty;
    logic [19:0]  victim_tag;
    logic [127:0] victim_data;
    logic         refill_valid;
    logic [19:0]  refill_tag;
    logic [7:0]   refill_index;
    logic [127:0] refill_data;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    cache_refill_engine dut (
        .clk          (clk),
        .resetn       (resetn),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_tag     (miss_tag),
        .miss_index   (miss_index),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .refill_valid (refill_valid),
        .refill_tag   (refill_tag),
        .refill_index (refill_index),
        .refill_data  (refill_data),
        .rd_req       (rd_req),
        .rd_type      (rd_type),
        .rd_addr      (rd_addr),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data),
        .wr_req       (wr_req),
        .wr_type      (wr_type),
        .wr_addr      (wr_addr),
        .wr_wstrb     (wr_wstrb),
        .wr_data      (wr_data),
        .wr_rdy       (wr_rdy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: which phases of the current miss are still
    // outstanding, the line as the responder has delivered it, and the
    // pending posted write.
    bit          m_rd_wait, m_collect, m_refill, m_wb;
    int          m_cnt;
    logic [31:0] m_line [4];
    logic [19:0] m_tag;
    logic [7:0]  m_index;
    logic [31:0] m_wb_addr;
    logic [127:0] m_wb_data;

    function automatic bit m_idle_ready();
        return !(m_rd_wait || m_collect || m_refill || m_wb);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_rd_wait = 0; m_collect = 0; m_refill = 0; m_wb = 0; m_cnt = 0;
            m_tag = '0; m_index = '0; m_wb_addr = '0; m_wb_data = '0;
            for (int i = 0; i < 4; i++) m_line[i] = '0;
        end else begin
            bit take;
            take = miss_valid && m_idle_ready();
            m_refill = 0;
            if (m_collect && ret_valid) begin
                m_line[m_cnt] = ret_data;
                m_cnt = (m_cnt + 1) % 4;
                if (ret_last) begin
                    m_collect = 0;
                    m_refill  = 1;
                end
            end
            if (m_rd_wait && rd_rdy) begin
                m_rd_wait = 0;
                m_collect = 1;
            end
            if (m_wb && wr_rdy) m_wb = 0;
            if (take) begin
                m_tag = miss_tag; m_index = miss_index; m_cnt = 0; m_rd_wait = 1;
                if (victim_dirty) begin
                    m_wb = 1;
                    m_wb_addr = {victim_tag, miss_index, 4'h0};
                    m_wb_data = victim_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && resetn) begin
            chk("miss_ready", miss_ready, m_idle_ready());
            chk("rd_req", rd_req, m_rd_wait);
            chk("rd_addr", rd_addr, {m_tag, m_index, 4'h0});
            chk("refill_valid", refill_valid, m_refill);
            if (m_refill) begin
                chk("refill_tag", refill_tag, m_tag);
                chk("refill_index", refill_index, m_index);
                chk("refill_data", refill_data, {m_line[3], m_line[2], m_line[1], m_line[0]});
            end
            chk("wr_req", wr_req, m_wb);
            if (m_wb) begin
                chk("wr_addr", wr_addr, m_wb_addr);
                chk("wr_data", wr_data, m_wb_data);
            end
            chk("rd_type", rd_type, 3'b100);
            chk("wr_type", wr_type, 3'b100);
            chk("wr_wstrb", wr_wstrb, 4'b1111);
        end
    end

    // which: 0 miss_ready, 1 rd_req, 2 wr_req
    task automatic wait_sig(input int which, input string name);
        int n = 0;
        logic v;
        v = (which == 0) ? miss_ready : (which == 1) ? rd_req : wr_req;
        while (!v && n < 100) begin
            @(negedge clk);
            n++;
            v = (which == 0) ? miss_ready : (which == 1) ? rd_req : wr_req;
        end
        if (!v) begin
            failures++;
            $display("FAIL timeout_%s actual=0 expected=1", name);
        end
    endtask

    task automatic issue_miss(input logic [19:0] t, input logic [7:0] idx, input bit dirty,
                              input logic [19:0] vt, input logic [127:0] vd);
        wait_sig(0, "miss_ready");
        miss_valid = 1; miss_tag = t; miss_index = idx;
        victim_dirty = dirty; victim_tag = vt; victim_data = vd;
        @(negedge clk);
        miss_valid = 0; victim_dirty = 0;
    endtask

    task automatic grant_rd();
        wait_sig(1, "rd_req");
        rd_rdy = 1;
        @(negedge clk);
        rd_rdy = 0;
    endtask

    task automatic send_beats(input logic [31:0] b0, b1, b2, b3, input int n, input bit gap);
        logic [31:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < n; i++) begin
            ret_valid = 1; ret_data = b[i]; ret_last = (i == n - 1);
            @(negedge clk);
            ret_valid = 0; ret_last = 0; ret_data = 32'hFFFF_FFFF;
            if (gap && i < n - 1) @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; miss_valid = 0; miss_tag = '0; miss_index = '0;
        victim_dirty = 0; victim_tag = '0; victim_data = '0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0; wr_rdy = 0;
        repeat (3) @(negedge clk);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_refill_valid", refill_valid, 0);
        chk("rst_rd_type", rd_type, 3'b100);
        chk("rst_wr_wstrb", wr_wstrb, 4'hF);
        resetn = 1; cmp_en = 1;
        @(negedge clk);
        chk("idle_miss_ready", miss_ready, 1);

        // Clean miss
        issue_miss(20'h12345, 8'h3c, 0, 20'h0, '0);
        chk("clean_rd_addr", rd_addr, 32'h1234_53c0);
        chk("clean_no_wr", wr_req, 0);
        grant_rd();
        send_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4, 0);
        chk("clean_refill_lat", refill_valid, 1);
        chk("clean_refill_data", refill_data, 128'h44444444_33333333_22222222_11111111);
        @(negedge clk);
        chk("clean_refill_pulse", refill_valid, 0);

        // Dirty miss, write held off for 10 cycles
        issue_miss(20'h12345, 8'h3c, 1, 20'hABCDE, {4{32'hA5A5A5A5}});
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    chk("dirty_wr_req_hold", wr_req, 1);
                    chk("dirty_wr_addr", wr_addr, 32'hABCD_E3C0);
                    @(negedge clk);
                end
                wr_rdy = 1;
                @(negedge clk);
                wr_rdy = 0;
                chk("dirty_wr_drop", wr_req, 0);
            end
            begin
                grant_rd();
                send_beats(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 4, 0);
                chk("dirty_refill", refill_valid, 1);
                @(negedge clk);
                chk("dirty_blocked", miss_ready, 0);
            end
        join
        chk("dirty_unblocked", miss_ready, 1);

        // Concurrent handshakes, then back-to-back miss
        issue_miss(20'h0F0F0, 8'h81, 1, 20'h13579, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("conc_rd_req", rd_req, 1);
        chk("conc_wr_req", wr_req, 1);
        rd_rdy = 1; wr_rdy = 1;
        @(negedge clk);
        rd_rdy = 0; wr_rdy = 0;
        chk("conc_rd_done", rd_req, 0);
        chk("conc_wr_done", wr_req, 0);
        send_beats(32'hC0C0_0001, 32'hC0C0_0002, 32'hC0C0_0003, 32'hC0C0_0004, 4, 0);
        chk("conc_refill", refill_valid, 1);
        miss_valid = 1; miss_tag = 20'h2468A; miss_index = 8'hF0; victim_dirty = 0;
        @(negedge clk);
        chk("b2b_ready", miss_ready, 1);
        @(negedge clk);
        miss_valid = 0;
        chk("b2b_rd_req", rd_req, 1);

        // Back-pressure with spurious return beats during the request phase
        for (int i = 0; i < 5; i++) begin
            chk("bp_rd_req", rd_req, 1);
            chk("bp_rd_addr", rd_addr, 32'h2468_AF00);
            ret_valid = (i % 2 == 0); ret_data = 32'hDEAD_0000 + i; ret_last = 1;
            @(negedge clk);
        end
        ret_valid = 0; ret_last = 0;
        grant_rd();

        // Gapped beats
        send_beats(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 4, 1);
        chk("gap_refill", refill_valid, 1);
        chk("gap_refill_data", refill_data, 128'hA0000004_A0000003_A0000002_A0000001);
        @(negedge clk);
        chk("gap_single_pulse", refill_valid, 0);

        // Early ret_last: upper words keep the previous line's contents
        issue_miss(20'h00001, 8'h02, 0, 20'h0, '0);
        grant_rd();
        send_beats(32'hB0000001, 32'hB0000002, 32'h0, 32'h0, 2, 0);
        chk("short_refill", refill_valid, 1);
        chk("short_refill_data", refill_data, 128'hA0000004_A0000003_B0000002_B0000001);
        @(negedge clk);

        // Reset during RD_DATA after two beats with a write pending
        issue_miss(20'h11111, 8'h22, 1, 20'h33333, {4{32'h5A5A5A5A}});
        grant_rd();
        ret_valid = 1; ret_last = 0; ret_data = 32'hE0000001;
        @(negedge clk);
        ret_data = 32'hE0000002;
        @(negedge clk);
        ret_valid = 0;
        chk("pre_rst_wr_req", wr_req, 1);
        #2;
        resetn = 0;
        #1;
        chk("mid_rst_rd_req", rd_req, 0);
        chk("mid_rst_wr_req", wr_req, 0);
        chk("mid_rst_refill", refill_valid, 0);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        issue_miss(20'hFEDCB, 8'h7E, 0, 20'h0, '0);
        chk("post_rst_rd_addr", rd_addr, 32'hFEDC_B7E0);
        grant_rd();
        send_beats(32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004, 4, 0);
        chk("post_rst_refill", refill_valid, 1);
        chk("post_rst_refill_data", refill_data, 128'hF0000004_F0000003_F0000002_F0000001);
        @(negedge clk);
        @(negedge clk);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
